// File: rtl/simon_arbiter.sv
// Round-robin job sequencer that shares one top_simon core among NREQ requesters.
// Define SIMON_ARB_TIMEOUT_EN to enable the WAIT watchdog (rsp_err_o); otherwise rsp_err_o is tied low.
module simon_arbiter #(
  parameter int NREQ           = 4,
  parameter int IDW            = $clog2(NREQ),
  parameter int TIMEOUT_CYCLES = 127
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ-1:0]            req_encrypt_i,
  input  logic [NREQ-1:0][127:0]     req_pt_i,
  input  logic [NREQ-1:0][127:0]     req_key_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [IDW-1:0]             rsp_id_o,
  output logic [127:0]               rsp_data_o,
  output logic                       rsp_err_o,
  output logic                       core_start_o,
  output logic                       core_encrypt_o,
  output logic [127:0]               core_pt_o,
  output logic [127:0]               core_k0_o,
  input  logic                       core_valid_i,
  input  logic [127:0]               core_ct_i
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;

`ifdef SIMON_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          err;
  assign rsp_err_o = err;
`else
  assign rsp_err_o = 1'b0;
`endif

  // Index rr_ptr+off modulo NREQ; both operands are below NREQ so one subtraction suffices.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Scan from the highest offset down so the lowest offset (closest to rr_ptr) wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid_i[wrap_idx(rr_ptr, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(rr_ptr, k);
      end
    end
  end

  // Ready is withheld while rst_n is low because that edge will not capture the job.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready_o[gi] = rst_n && (state == IDLE) && grant_found && (grant_idx == IDW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      core_start_o   <= 1'b0;
      core_encrypt_o <= 1'b0;
      core_pt_o      <= '0;
      core_k0_o      <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_id_o       <= '0;
      rsp_data_o     <= '0;
`ifdef SIMON_ARB_TIMEOUT_EN
      wait_cnt       <= '0;
      err            <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            core_encrypt_o <= req_encrypt_i[grant_idx];
            core_pt_o      <= req_pt_i[grant_idx];
            core_k0_o      <= req_key_i[grant_idx];
            rsp_id_o       <= grant_idx;
            rr_ptr         <= wrap_idx(grant_idx, 1);
            core_start_o   <= 1'b1;
            state          <= LAUNCH;
          end
        end
        LAUNCH: begin
          core_start_o <= 1'b0;
          state        <= WAIT;
`ifdef SIMON_ARB_TIMEOUT_EN
          wait_cnt     <= '0;
`endif
        end
        WAIT: begin
          // A core valid in the final watchdog cycle still counts as a good result.
          if (core_valid_i) begin
            rsp_data_o  <= core_ct_i;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
`ifdef SIMON_ARB_TIMEOUT_EN
            err         <= 1'b0;
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            rsp_data_o  <= '0;
            err         <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt    <= wait_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_arbiter.sv
// Self-checking bench for simon_arbiter: stub core, job-level reference model, directed and random stimulus.
module tb_simon_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef SIMON_ARB_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 127;
`endif
  localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PT  = 128'h63736564207372656c6c657661727420;
  localparam logic [127:0] CT  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N-1:0]          req_valid, req_encrypt, req_ready;
  logic [N-1:0][127:0]   req_pt, req_key;
  logic                  rsp_valid, rsp_ready, rsp_err;
  logic [IDW-1:0]        rsp_id;
  logic [127:0]          rsp_data;
  logic                  core_start, core_encrypt, core_valid;
  logic [127:0]          core_pt, core_k0, core_ct;

  simon_arbiter #(.NREQ(N), .IDW(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_encrypt_i(req_encrypt),
    .req_pt_i(req_pt), .req_key_i(req_key),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .core_start_o(core_start), .core_encrypt_o(core_encrypt), .core_pt_o(core_pt),
    .core_k0_o(core_k0), .core_valid_i(core_valid), .core_ct_i(core_ct)
  );

  always #5 clk = ~clk;

  // Stand-in for top_simon: knows the published vector, otherwise an invertible scramble.
  function automatic logic [127:0] core_fn(input logic e, input logic [127:0] p, input logic [127:0] k);
    if (e && p == PT && k == KEY) return CT;
    if (!e && p == CT && k == KEY) return PT;
    return p ^ {k[63:0], k[127:64]} ^ {128{e}};
  endfunction

  // Stub core: latency lat_cfg (0 = never answers); garbage valids while idle.
  int          lat_cfg = 5;
  logic        stale_en = 1'b0, stale_always = 1'b0;
  int          s_cnt;
  logic        s_busy, s_enc;
  logic [127:0] s_pt, s_key;
  always @(posedge clk) begin
    if (!rst_n) begin
      s_busy <= 1'b0; s_cnt <= 0; core_valid <= 1'b0; core_ct <= '0;
    end else if (core_start) begin
      s_busy <= 1'b1; s_cnt <= lat_cfg; core_valid <= 1'b0;
      s_enc <= core_encrypt; s_pt <= core_pt; s_key <= core_k0;
    end else if (s_busy) begin
      if (s_cnt == 1) begin
        core_valid <= 1'b1; core_ct <= core_fn(s_enc, s_pt, s_key); s_busy <= 1'b0;
      end else begin
        core_valid <= 1'b0;
        if (s_cnt != 0) s_cnt <= s_cnt - 1;
      end
    end else begin
      core_valid <= stale_always | (stale_en & ($urandom_range(0, 3) == 0));
      core_ct    <= {$urandom, $urandom, $urandom, $urandom};
    end
  end

  int n_assert = 0, n_fail = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Job-level reference model: which job is pending and where it is in its life.
  localparam int P_IDLE = 0, P_LAUNCH = 1, P_WAIT = 2, P_RESP = 3;
  int           phase = P_IDLE, m_rr = 0, m_id = 0, m_wait = 0;
  logic         m_known = 1'b0, m_enc = 1'b0, m_err = 1'b0;
  logic [127:0] m_pt = '0, m_key = '0, m_data = '0;
  int           ready_pulses = 0, start_pulses = 0;
  int           grant_log[$];

  // Runs at negedge, when inputs for the coming edge are stable.
  task automatic check_cycle();
    logic [N-1:0] exp_rdy;
    int g;
    g = -1;
    exp_rdy = '0;
    if (m_known) begin
      if (rst_n && phase == P_IDLE)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("core_start", core_start, phase == P_LAUNCH);
      chk("rsp_valid", rsp_valid, phase == P_RESP);
      if (phase == P_RESP) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_err", rsp_err, m_err);
      end
`ifndef SIMON_ARB_TIMEOUT_EN
      chk("rsp_err_tied", rsp_err, 1'b0);
`endif
      if (phase == P_LAUNCH || phase == P_WAIT) begin
        chk("core_encrypt", core_encrypt, m_enc);
        chk("core_pt", core_pt, m_pt);
        chk("core_k0", core_k0, m_key);
      end
      if (|req_ready) begin
        ready_pulses++;
        for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
      end
      if (core_start) start_pulses++;
    end
    if (!rst_n) begin
      m_known = 1'b1; phase = P_IDLE; m_rr = 0; m_id = 0;
      m_enc = 1'b0; m_pt = '0; m_key = '0; m_data = '0; m_err = 1'b0;
    end else if (m_known) begin
      case (phase)
        P_IDLE: if (g >= 0) begin
          m_id = g; m_enc = req_encrypt[g]; m_pt = req_pt[g]; m_key = req_key[g];
          m_rr = (g + 1) % N; phase = P_LAUNCH;
        end
        P_LAUNCH: begin phase = P_WAIT; m_wait = 0; end
        P_WAIT: begin
          if (core_valid) begin
            m_data = core_fn(m_enc, m_pt, m_key); m_err = 1'b0; phase = P_RESP;
`ifdef SIMON_ARB_TIMEOUT_EN
          end else if (m_wait == TO - 1) begin
            m_data = '0; m_err = 1'b1; phase = P_RESP;
`endif
          end else m_wait++;
        end
        default: if (rsp_ready) phase = P_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string name, input int lim);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < lim) begin tick(); n++; end
    chk(name, rsp_valid, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0; rsp_ready = 1'b1;
    while (phase != P_IDLE && n < 300) begin tick(); n++; end
    chk("drain_idle", phase == P_IDLE, 1'b1);
    rsp_ready = 1'b0;
  endtask

  task automatic send(input int r, input logic e, input logic [127:0] p, input logic [127:0] k);
    req_valid = '0; req_valid[r] = 1'b1;
    req_encrypt[r] = e; req_pt[r] = p; req_key[r] = k;
    tick();
    req_valid = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  initial begin
    int n, hits, sp;
    logic [127:0] held;
    rst_n = 1'b0; req_valid = '0; req_encrypt = '0; req_pt = '0; req_key = '0; rsp_ready = 1'b0;
    apply_reset();
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_core_start", core_start, 1'b0);
    chk("reset_rsp_data", rsp_data, 128'h0);

    // Single encrypt with the published vector.
    ready_pulses = 0; start_pulses = 0;
    send(0, 1'b1, PT, KEY);
    wait_rsp("enc_wait", 200);
    chk("enc_id", rsp_id, 0);
    chk("enc_data", rsp_data, CT);
    chk("enc_ready_pulses", ready_pulses, 1);
    chk("enc_start_pulses", start_pulses, 1);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // Decrypt round trip through requester 2.
    send(2, 1'b0, CT, KEY);
    wait_rsp("dec_wait", 200);
    chk("dec_id", rsp_id, 2);
    chk("dec_data", rsp_data, PT);
    drain();

    // Round robin from a fresh pointer: all four requesting.
    apply_reset();
    chk("rr_reset_core_pt", core_pt, 128'h0);
    grant_log.delete();
    for (int i = 0; i < N; i++) begin
      req_encrypt[i] = i[0]; req_pt[i] = {4{$urandom}}; req_key[i] = {4{$urandom}};
    end
    req_valid = '1; rsp_ready = 1'b1;
    n = 0;
    while (grant_log.size() < 5 && n < 500) begin tick(); n++; end
    chk("rr_grants", grant_log.size() >= 5, 1'b1);
    if (grant_log.size() >= 5) begin
      chk("rr_g0", grant_log[0], 0);
      chk("rr_g1", grant_log[1], 1);
      chk("rr_g2", grant_log[2], 2);
      chk("rr_g3", grant_log[3], 3);
      chk("rr_g4_wrap", grant_log[4], 0);
    end
    drain();

    // Backpressure: response held 20 cycles while everyone requests.
    send(1, 1'b1, 128'h1234, 128'h5678);
    req_valid = '1;
    wait_rsp("bp_wait", 200);
    held = rsp_data; sp = start_pulses;
    repeat (20) tick();
    chk("bp_still_valid", rsp_valid, 1'b1);
    chk("bp_data_stable", rsp_data, held);
    chk("bp_no_start", start_pulses, sp);
    rsp_ready = 1'b1; req_valid = '0; tick(); rsp_ready = 1'b0;
    chk("bp_release_idle", rsp_valid, 1'b0);
    drain();

    // Stale core valid before start, then reset in WAIT.
    stale_always = 1'b1; lat_cfg = 0;
    send(1, 1'b0, 128'hdead, 128'hbeef);
    n = 0;
    while (core_start !== 1'b1 && n < 20) begin tick(); n++; end
    chk("stale_start_seen", core_start, 1'b1);
    repeat (4) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rstw_ready", req_ready, 4'h0);
    chk("rstw_rsp_valid", rsp_valid, 1'b0);
    chk("rstw_rsp_id", rsp_id, 0);
    chk("rstw_rsp_data", rsp_data, 128'h0);
    chk("rstw_rsp_err", rsp_err, 1'b0);
    chk("rstw_core_start", core_start, 1'b0);
    chk("rstw_core_enc", core_encrypt, 1'b0);
    chk("rstw_core_pt", core_pt, 128'h0);
    chk("rstw_core_k0", core_k0, 128'h0);
    hits = 0;
    repeat (20) begin tick(); if (rsp_valid === 1'b1) hits++; end
    chk("rstw_no_response", hits, 0);
    stale_always = 1'b0;

    // Randomized traffic with stale valids, random latency and backpressure.
    stale_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i]   = ($urandom_range(0, 2) == 0);
        req_encrypt[i] = $urandom_range(0, 1);
        req_pt[i]      = {$urandom, $urandom, $urandom, $urandom};
        req_key[i]     = {$urandom, $urandom, $urandom, $urandom};
      end
      rsp_ready = $urandom_range(0, 1);
      lat_cfg   = $urandom_range(1, 12);
      tick();
    end
    drain();
    stale_en = 1'b0;

`ifdef SIMON_ARB_TIMEOUT_EN
    lat_cfg = 0;
    send(3, 1'b1, 128'h77, 128'h88);
    n = 0;
    while (core_start !== 1'b1 && n < 20) begin tick(); n++; end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin tick(); n++; end
    chk("to_cycles", n, TO + 1);
    chk("to_err", rsp_err, 1'b1);
    chk("to_data", rsp_data, 128'h0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
